// File: rtl/v_tile_out_router.sv
// v_tile_out_router: output stage of the vector tile.
// Buffers adder FU results (num_inputs lanes of width bits plus a 4-bit destination mask)
// in a small FIFO, then delivers each result over the CGRA write handshake to every
// selected neighbour (bit0=N, bit1=E, bit2=S, bit3=W).
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   result_in, dest_in    result lanes and destination mask, sampled when result_valid=1
//   result_valid          1-cycle push strobe
//   out_write_en          per-neighbour write request (held until ack)
//   out_write_rdy/ack     per-neighbour ready and acknowledge
//   out_data              payload shared by all four neighbour ports
//   fifo_count            occupied FIFO entries (active result not included)
//   busy                  a result is being delivered
//   overflow              sticky flag: a result was dropped on a full FIFO
module v_tile_out_router #(
  parameter int unsigned width      = 16,
  parameter int unsigned num_inputs = 4,
  parameter int unsigned depth      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [width-1:0]       result_in [num_inputs],
  input  logic [3:0]             dest_in,
  input  logic                   result_valid,
  output logic [3:0]             out_write_en,
  input  logic [3:0]             out_write_rdy,
  input  logic [3:0]             out_write_ack,
  output logic [width-1:0]       out_data [num_inputs],
  output logic [$clog2(depth):0] fifo_count,
  output logic                   busy,
  output logic                   overflow
);

  localparam int unsigned PtrW = $clog2(depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(depth);

  // StLoadWait is a reserved transitional state; it only falls back to StIdle.
  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StLoadWait = 2'd1,
    StSend     = 2'd2
  } state_e;

  state_e           state_q;
  logic [width-1:0] mem_data_q [depth][num_inputs];
  logic [3:0]       mem_dest_q [depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [3:0]       pending_q;

  logic       pop;
  logic       push_ok;
  logic [3:0] en_set;
  logic [3:0] ack_clr;
  logic [3:0] pending_d;

  always_comb begin
    // Pop only from an idle engine, so a retire and the next pop never share an edge.
    pop       = (state_q == StIdle) && (fifo_count != '0);
    // A full FIFO still accepts a push when the head leaves at the same edge.
    push_ok   = result_valid && ((fifo_count < FullCnt) || pop);
    en_set    = pending_q & ~out_write_en & out_write_rdy;
    // Ack only counts while the request is up.
    ack_clr   = pending_q & out_write_en & out_write_ack;
    pending_d = pending_q & ~ack_clr;
  end

  // Storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      for (int l = 0; l < num_inputs; l++) begin
        mem_data_q[wr_ptr_q][l] <= result_in[l];
      end
      mem_dest_q[wr_ptr_q] <= dest_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count   <= '0;
      out_write_en <= '0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
      for (int l = 0; l < num_inputs; l++) begin
        out_data[l] <= '0;
      end
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);

      if (push_ok && !pop) begin
        fifo_count <= fifo_count + CntW'(1);
      end else if (!push_ok && pop) begin
        fifo_count <= fifo_count - CntW'(1);
      end

      if (result_valid && !push_ok) overflow <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (pop) begin
            for (int l = 0; l < num_inputs; l++) begin
              out_data[l] <= mem_data_q[rd_ptr_q][l];
            end
            pending_q <= mem_dest_q[rd_ptr_q];
            // A zero mask retires right here without any handshake.
            if (mem_dest_q[rd_ptr_q] != 4'b0000) begin
              state_q <= StSend;
              busy    <= 1'b1;
            end
          end
        end
        StSend: begin
          out_write_en <= (out_write_en | en_set) & ~ack_clr;
          pending_q    <= pending_d;
          if (pending_d == 4'b0000) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        StLoadWait: state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_v_tile_out_router.sv
// Testbench for v_tile_out_router: directed scenarios followed by random traffic, all checked
// every cycle against a queue-based transaction model of the router.
module tb_v_tile_out_router;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int D  = 2;
  localparam int CW = $clog2(D) + 1;

  typedef struct packed {
    logic [N*W-1:0] data;
    logic [3:0]     dest;
  } entry_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [W-1:0]   result_in [N];
  logic [3:0]     dest_in;
  logic           result_valid;
  logic [3:0]     out_write_en;
  logic [3:0]     out_write_rdy;
  logic [3:0]     out_write_ack;
  logic [W-1:0]   out_data [N];
  logic [CW-1:0]  fifo_count;
  logic           busy;
  logic           overflow;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  entry_t         m_q[$];
  logic [N*W-1:0] m_data;
  logic [3:0]     m_pend;
  logic [3:0]     m_en;
  logic           m_busy;
  logic           m_ovf;
  int             hi_cnt [4];
  int             ack_dly [4];
  bit             auto_ack;
  string          phase;

  always #5 clk = ~clk;

  v_tile_out_router #(
    .width      (W),
    .num_inputs (N),
    .depth      (D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .result_in     (result_in),
    .dest_in       (dest_in),
    .result_valid  (result_valid),
    .out_write_en  (out_write_en),
    .out_write_rdy (out_write_rdy),
    .out_write_ack (out_write_ack),
    .out_data      (out_data),
    .fifo_count    (fifo_count),
    .busy          (busy),
    .overflow      (overflow)
  );

  function automatic void model_reset();
    m_q.delete();
    m_data = '0;
    m_pend = '0;
    m_en   = '0;
    m_busy = 1'b0;
    m_ovf  = 1'b0;
    for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
  endfunction

  // One clock edge of the router at transaction level: deliver, accept, then dequeue.
  function automatic void model_edge();
    entry_t         h;
    logic [N*W-1:0] d;
    bit             do_pop;
    bit             accept;
    do_pop = !m_busy && (m_q.size() > 0);
    if (m_busy) begin
      for (int i = 0; i < 4; i++) begin
        if (m_pend[i]) begin
          if (!m_en[i] && out_write_rdy[i]) begin
            m_en[i] = 1'b1;
          end else if (m_en[i] && out_write_ack[i]) begin
            m_en[i]   = 1'b0;
            m_pend[i] = 1'b0;
          end
        end
      end
      if (m_pend == 4'b0000) m_busy = 1'b0;
    end
    accept = result_valid && ((m_q.size() < D) || do_pop);
    if (result_valid && !accept) m_ovf = 1'b1;
    if (do_pop) begin
      h      = m_q.pop_front();
      m_data = h.data;
      m_pend = h.dest;
      m_busy = (h.dest != 4'b0000);
    end
    if (accept) begin
      for (int l = 0; l < N; l++) d[l*W +: W] = result_in[l];
      m_q.push_back('{data: d, dest: dest_in});
    end
    for (int i = 0; i < 4; i++) hi_cnt[i] = m_en[i] ? hi_cnt[i] + 1 : 0;
  endfunction

  task automatic check(input string tag);
    logic [N*W-1:0] got;
    logic [CW-1:0]  exp_cnt;
    for (int l = 0; l < N; l++) got[l*W +: W] = out_data[l];
    exp_cnt = CW'(m_q.size());
    vectors++;
    assert (out_write_en === m_en) else begin
      miscompares++;
      $error("FAIL %s write_en got %b want %b", tag, out_write_en, m_en);
    end
    vectors++;
    assert (got === m_data) else begin
      miscompares++;
      $error("FAIL %s out_data got %h want %h", tag, got, m_data);
    end
    vectors++;
    assert (fifo_count === exp_cnt) else begin
      miscompares++;
      $error("FAIL %s fifo_count got %0d want %0d", tag, fifo_count, exp_cnt);
    end
    vectors++;
    assert (busy === m_busy) else begin
      miscompares++;
      $error("FAIL %s busy got %b want %b", tag, busy, m_busy);
    end
    vectors++;
    assert (overflow === m_ovf) else begin
      miscompares++;
      $error("FAIL %s overflow got %b want %b", tag, overflow, m_ovf);
    end
  endtask

  // Inputs change only at the falling edge; outputs are checked there too.
  task automatic step();
    if (auto_ack) begin
      for (int i = 0; i < 4; i++) out_write_ack[i] = m_en[i] && (hi_cnt[i] > ack_dly[i]);
    end
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
    check(phase);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic push(input logic [N*W-1:0] d, input logic [3:0] dst);
    for (int l = 0; l < N; l++) result_in[l] = d[l*W +: W];
    dest_in      = dst;
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    run(2);
    reset = 1'b1;
  endtask

  task automatic set_dly(input int n, input int e, input int s, input int w);
    ack_dly[0] = n;
    ack_dly[1] = e;
    ack_dly[2] = s;
    ack_dly[3] = w;
  endtask

  initial begin
    bit pushed;
    for (int l = 0; l < N; l++) result_in[l] = '0;
    dest_in       = '0;
    result_valid  = 1'b0;
    out_write_rdy = '0;
    out_write_ack = '0;
    auto_ack      = 1'b1;
    set_dly(1, 1, 1, 1);
    model_reset();

    phase = "reset";
    @(negedge clk);
    check(phase);
    do_reset();

    phase = "unicast";
    out_write_rdy = 4'b0010;
    push({16'd4, 16'd3, 16'd2, 16'd1}, 4'b0010);
    run(6);

    phase = "multicast";
    out_write_rdy = 4'b1111;
    set_dly(1, 3, 0, 5);
    push(64'h000a_000b_000c_000d, 4'b1011);
    push(64'h1111_2222_3333_4444, 4'b0001);
    run(14);

    phase = "rdy_gate";
    set_dly(1, 1, 1, 1);
    out_write_rdy = 4'b1011;
    push(64'hcafe_f00d_beef_1234, 4'b0100);
    run(6);
    out_write_rdy = 4'b1111;
    run(5);

    phase = "overflow";
    out_write_rdy = 4'b0000;
    push(64'h0001_0001_0001_0001, 4'b0001);
    push(64'h0002_0002_0002_0002, 4'b0010);
    push(64'h0003_0003_0003_0003, 4'b0100);
    push(64'h0004_0004_0004_0004, 4'b1000);
    run(3);
    out_write_rdy = 4'b1111;
    run(25);

    phase = "full_pop";
    do_reset();
    set_dly(0, 0, 0, 0);
    out_write_rdy = 4'b0000;
    push(64'haaaa_0000_0000_0001, 4'b0001);
    push(64'hbbbb_0000_0000_0002, 4'b0010);
    push(64'hcccc_0000_0000_0003, 4'b0100);
    out_write_rdy = 4'b1111;
    pushed = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!pushed && !m_busy && (m_q.size() == D)) begin
        push(64'hdddd_0000_0000_0004, 4'b1000);
        pushed = 1'b1;
      end else begin
        step();
      end
    end
    vectors++;
    assert (pushed) else begin
      miscompares++;
      $error("FAIL full_pop_window got %b want %b", pushed, 1'b1);
    end
    run(5);

    phase = "zero_dest";
    push(64'h0bad_0bad_0bad_0bad, 4'b0000);
    run(3);

    phase = "reset_mid";
    set_dly(10, 10, 10, 10);
    push(64'h7777_6666_5555_4444, 4'b1000);
    run(3);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("reset_async");
    step();
    reset = 1'b1;
    phase = "after_reset";
    set_dly(1, 1, 1, 1);
    push(64'h9999_8888_7777_6666, 4'b1000);
    run(8);

    phase = "random";
    do_reset();
    auto_ack = 1'b0;
    for (int k = 0; k < 400; k++) begin
      result_valid = ($urandom_range(0, 99) < 40);
      for (int l = 0; l < N; l++) result_in[l] = W'($urandom);
      dest_in       = 4'($urandom_range(0, 15));
      out_write_rdy = 4'($urandom);
      out_write_ack = 4'($urandom);
      step();
    end
    result_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/v_tile_out_router.md
Name: v_tile_out_router

Overview:
- Downstream stage of the vector tile. Consumes the adder FU result bundle: num_inputs lanes of width bits, a 4-bit destination field, and a 1-cycle valid pulse.
- Buffers results in a small FIFO and delivers each one over the CGRA write handshake to every neighbour selected in the destination field.
- Sits between the tile's adder FU outputs and the neighbour tiles' memory write ports.

Parameters:
- width, 16, bit width of each result lane
- num_inputs, 4, lanes per result
- depth, 2, FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- result_in  in  width x num_inputs (unpacked array)  adder result lanes
- dest_in  in  4  destination mask, one bit per neighbour port: bit0=N, bit1=E, bit2=S, bit3=W
- result_valid  in  1  1-cycle pulse; result_in and dest_in are valid in that cycle
- out_write_en  out  4  per-neighbour write request
- out_write_rdy  in  4  per-neighbour ready
- out_write_ack  in  4  per-neighbour acknowledge
- out_data  out  width x num_inputs  payload shared by all four ports
- fifo_count  out  $clog2(depth)+1  occupied entries
- busy  out  1  a result is being delivered
- overflow  out  1  sticky: a result was dropped

Behaviour:
- Reset (async, active-low): FIFO empty, fifo_count=0, out_write_en=0, out_data=0, busy=0, overflow=0. Outputs clear immediately on reset assertion, including mid-handshake. The in-flight result is discarded.
- Push: at a clk edge with result_valid=1, {result_in, dest_in} is written at the tail.
  - The push is accepted if fifo_count<depth, or if a pop occurs at the same edge.
  - Otherwise the result is dropped and overflow is set to 1. overflow is cleared only by reset.
- Engine FSM states: IDLE, LOAD_WAIT, SEND.
- IDLE: at an edge where the FIFO is non-empty, pop the head into the active register. out_data takes the head lanes and pending[3:0] takes the head dest.
  - If dest != 0, go to SEND and set busy=1.
  - If dest == 0, the entry is retired at the pop edge; stay in IDLE and set no write_en.
- SEND, per port i with pending[i]=1:
  - At an edge where out_write_en[i]=0 and out_write_rdy[i]=1, set out_write_en[i]=1.
  - out_write_en[i] stays high until an edge where out_write_ack[i]=1. At that edge set out_write_en[i]=0 and pending[i]=0.
  - out_write_ack[i] is ignored while out_write_en[i]=0.
  - out_write_rdy[i] may drop after write_en rises; out_write_en[i] still holds until ack.
- Ports are independent: different neighbours may ack in any order or at the same edge.
- When pending becomes 0 at an edge: busy=0, state=IDLE. The next pop can occur at the following edge, never at the same edge.
- out_data is stable from pop until retirement; it holds its last value while idle.
- Latency, empty FIFO with all rdy high: valid at E0 → pop at E1 → write_en high after E2 → ack sampled at E3 earliest → retire at E3 → next pop at E4.
- fifo_count changes by -1, 0, or +1 per edge. Simultaneous push and pop with the FIFO full leaves count=depth and sets no overflow.
- FIFO pointers wrap modulo depth.
- LOAD_WAIT is reserved (unused transitional state). It must encode distinctly and return to IDLE.

Test Plan:
- Single unicast: reset release; result_valid pulse with lanes {1,2,3,4}, dest=4'b0010, E rdy=1; ack 1 cycle after write_en rises → out_data={1,2,3,4}, only out_write_en[1] pulses, high 2 cycles, fifo_count 1→0, busy falls on the ack edge.
- Multicast with skewed acks: dest=4'b1011; ack N at +1, E at +3, W at +5 cycles → each en drops independently on its own ack; busy stays 1 until W ack; next entry pops the edge after that.
- Ready gating: dest=4'b0100 with S rdy=0 for 6 cycles, then 1 → write_en[2] stays 0 until the edge after rdy rises; payload unchanged throughout.
- Overflow (depth=2): hold all rdy=0 and push 4 results on consecutive cycles → first pops to active, next two fill the FIFO (count=2), fourth dropped, overflow=1 and stays 1 after later drains.
- Full plus simultaneous pop: FIFO full, final ack retires the active result, push at the same edge as the subsequent pop → count stays 2, overflow stays 0, pushed data delivered in order.
- Zero dest and reset mid-send: dest=0 retires with no write_en; during SEND with write_en[3]=1, assert reset between edges → write_en drops immediately, count=0; after release, a new result is delivered normally.
